// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU among NUM_REQ requesters.
// Results return in issue order through an output register backed by a one-entry skid.
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [7:0]           alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [7:0]           resp_result,
  output logic [2:0]           resp_flags,
  output logic [CNT_W-1:0]     stat_issued,
  output logic [CNT_W-1:0]     stat_stall
);

  logic [ID_W-1:0]  ptr_reg;
  logic             inflight_reg;
  logic [ID_W-1:0]  inflight_id_reg;
  logic             out_valid_reg;
  logic [ID_W-1:0]  out_id_reg;
  logic [7:0]       out_result_reg;
  logic [2:0]       out_flags_reg;
  logic             skid_valid_reg;
  logic [ID_W-1:0]  skid_id_reg;
  logic [7:0]       skid_result_reg;
  logic [2:0]       skid_flags_reg;
  logic [CNT_W-1:0] stat_issued_reg;
  logic [CNT_W-1:0] stat_stall_reg;

  logic [7:0]         a_arr  [NUM_REQ];
  logic [7:0]         b_arr  [NUM_REQ];
  logic [2:0]         op_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               any_grant;
  logic               issue_ok;
  logic               fire;
  logic               resp_hs;
  logic [2:0]         cap_flags;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[8*gi +: 8];
      assign b_arr[gi]  = req_b[8*gi +: 8];
      assign op_arr[gi] = req_op[3*gi +: 3];
      assign grant[gi]  = any_grant && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Scan from the far end back toward ptr so the nearest valid requester wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_sel;
    any_grant = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_sel = ID_W'(idx);
      if (req_valid[idx_sel]) begin
        any_grant = 1'b1;
        grant_id  = idx_sel;
      end
    end
  end

  // Never issue when the op could land on an occupied skid register.
  assign issue_ok  = !skid_valid_reg && !(inflight_reg && out_valid_reg && !resp_ready);
  assign fire      = any_grant && issue_ok && !rst;
  assign req_ready = fire ? grant : '0;

  assign alu_a      = fire ? a_arr[grant_id]  : '0;
  assign alu_b      = fire ? b_arr[grant_id]  : '0;
  assign alu_opcode = fire ? op_arr[grant_id] : '0;

  assign resp_hs   = out_valid_reg && resp_ready;
  assign cap_flags = {alu_overflow, alu_carry, alu_zero};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg         <= '0;
      inflight_reg    <= 1'b0;
      inflight_id_reg <= '0;
    end else begin
      inflight_reg <= fire;
      if (fire) begin
        inflight_id_reg <= grant_id;
        ptr_reg         <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_id_reg      <= '0;
      out_result_reg  <= '0;
      out_flags_reg   <= '0;
      skid_valid_reg  <= 1'b0;
      skid_id_reg     <= '0;
      skid_result_reg <= '0;
      skid_flags_reg  <= '0;
    end else if (inflight_reg) begin
      if (!out_valid_reg || resp_hs) begin
        out_valid_reg  <= 1'b1;
        out_id_reg     <= inflight_id_reg;
        out_result_reg <= alu_result;
        out_flags_reg  <= cap_flags;
      end else begin
        skid_valid_reg  <= 1'b1;
        skid_id_reg     <= inflight_id_reg;
        skid_result_reg <= alu_result;
        skid_flags_reg  <= cap_flags;
      end
    end else if (resp_hs) begin
      if (skid_valid_reg) begin
        out_id_reg     <= skid_id_reg;
        out_result_reg <= skid_result_reg;
        out_flags_reg  <= skid_flags_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_reg <= '0;
      stat_stall_reg  <= '0;
    end else begin
      if (fire) stat_issued_reg <= stat_issued_reg + CNT_W'(1);
      if (|req_valid && !fire) stat_stall_reg <= stat_stall_reg + CNT_W'(1);
    end
  end

  assign resp_valid  = out_valid_reg;
  assign resp_id     = out_id_reg;
  assign resp_result = out_result_reg;
  assign resp_flags  = out_flags_reg;
  assign stat_issued = stat_issued_reg;
  assign stat_stall  = stat_stall_reg;

endmodule
